// File: rtl/clk_gen_multi.sv
// Multi-channel programmable refclk divider with phase alignment and lock indication.
// outclk/tick are registered (1 cycle after the counter value); cfg_ready drops only in ALIGN and during rst.
module clk_gen_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEF_DIV     = 4,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  localparam int SET_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {ALIGN, SETTLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               cfg_fire, cfg_bad, cfg_apply;

  logic [DIV_W-1:0]   div_q   [NUM_CH];
  logic [DIV_W-1:0]   high_q  [NUM_CH];
  logic [DIV_W-1:0]   phase_q [NUM_CH];
  logic [DIV_W-1:0]   cnt_q   [NUM_CH];
  logic [NUM_CH-1:0]  outclk_q, tick_q;
  logic               locked_q, cfg_err_q;

  always_comb begin
    cfg_ready = ~rst & (state_q != ALIGN);
    cfg_fire  = cfg_valid & cfg_ready;
    cfg_bad   = (cfg_div == '0) | (cfg_high > cfg_div) | (cfg_phase >= cfg_div) |
                (int'(cfg_ch) >= NUM_CH);
    cfg_apply = cfg_fire & ~cfg_bad;
    state_d   = state_q;
    settle_d  = settle_q;
    case (state_q)
      ALIGN: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
      SETTLE: begin
        if (settle_q == SET_W'(LOCK_CYCLES - 1)) state_d = LOCKED;
        else settle_d = settle_q + SET_W'(1);
      end
      default: ;
    endcase
    // Any accepted write restarts alignment, including one made mid-settle.
    if (cfg_apply) state_d = ALIGN;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ALIGN;
      settle_q  <= '0;
      locked_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      outclk_q  <= '0;
      tick_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_W'(DEF_DIV);
        high_q[i]  <= DIV_W'(DEF_DIV / 2);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      locked_q  <= (state_d == LOCKED);
      cfg_err_q <= cfg_fire & cfg_bad;
      for (int i = 0; i < NUM_CH; i++) begin
        outclk_q[i] <= (cnt_q[i] < high_q[i]);
        tick_q[i]   <= (cnt_q[i] == '0);
        // Outputs keep running through ALIGN; only the counter phase is reloaded.
        if (state_q == ALIGN)                      cnt_q[i] <= phase_q[i];
        else if (cnt_q[i] == div_q[i] - DIV_W'(1)) cnt_q[i] <= '0;
        else                                       cnt_q[i] <= cnt_q[i] + DIV_W'(1);
        if (cfg_apply && (cfg_ch == CH_W'(i))) begin
          div_q[i]   <= cfg_div;
          high_q[i]  <= cfg_high;
          phase_q[i] <= cfg_phase;
        end
      end
    end
  end

  assign outclk  = outclk_q;
  assign tick    = tick_q;
  assign locked  = locked_q;
  assign cfg_err = cfg_err_q;

endmodule
